// File: rtl/mem_port_master.sv
// Initiator for the 4096x16 main-memory port: single/burst read and write commands,
// zero-latency write beats, registered backpressured read responses.
// Optional MEM_CLEAR_ON_RESET_EN: zero the whole memory after every reset before accepting commands.
module mem_port_master #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int LEN_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [DW-1:0]    wr_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DW-1:0]    rsp_data_o,
  output logic             rsp_last_o,
  output logic             busy_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i
);

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {IDLE, WR, RD, CLR} state_t;
  localparam state_t RST_ST = CLR;
`else
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam state_t RST_ST = IDLE;
`endif

  state_t           state_q;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             rsp_valid_q, rsp_last_q;
  logic [DW-1:0]    rsp_data_q;
  logic             rd_cap, last_beat;

  assign addr_d    = addr_q + AW'(1);
  assign count_d   = count_q - LEN_W'(1);
  assign last_beat = (count_q == '0);
  // A read beat may only be captured once the response slot is free or draining.
  assign rd_cap    = (state_q == RD) && (!rsp_valid_q || rsp_ready_i);

  assign cmd_ready_o = (state_q == IDLE);
  assign wr_ready_o  = (state_q == WR);
  assign busy_o      = (state_q != IDLE);
  assign mem_addr_o  = addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;

`ifdef MEM_CLEAR_ON_RESET_EN
  assign mem_we_o    = rst_n_i && (((state_q == WR) && wr_valid_i) || (state_q == CLR));
  assign mem_wdata_o = (state_q == CLR) ? '0 : wr_data_i;
`else
  assign mem_we_o    = rst_n_i && (state_q == WR) && wr_valid_i;
  assign mem_wdata_o = wr_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= RST_ST;
      addr_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      // Consumed response drops unless overwritten by a capture below.
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
        rsp_last_q  <= 1'b0;
      end
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          addr_q  <= cmd_addr_i;
          count_q <= cmd_len_i;
          state_q <= cmd_we_i ? WR : RD;
        end
        WR: if (wr_valid_i) begin
          addr_q <= addr_d;
          if (last_beat) state_q <= IDLE;
          else           count_q <= count_d;
        end
        RD: if (rd_cap) begin
          rsp_data_q  <= mem_rdata_i;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= last_beat;
          addr_q      <= addr_d;
          if (last_beat) state_q <= IDLE;
          else           count_q <= count_d;
        end
`ifdef MEM_CLEAR_ON_RESET_EN
        CLR: begin
          addr_q <= addr_d;
          if (addr_q == '1) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Randomized bench for mem_port_master: behavioural memory, plus a reference model of
// expected memory image, write pulses and read responses derived from command semantics.
module tb_mem_port_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [11:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [15:0] rsp_data;
  logic        busy, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_master dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .busy_o(busy), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Memory device: combinational read, write on the clock edge.
  logic [15:0] mem [4096];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct packed { logic [11:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [15:0] d; logic l; } rd_t;

  logic [15:0] exp_mem [4096];
  wr_t         wq[$];
  rd_t         rq[$];
  logic [15:0] wdq[$];
  logic [15:0] dpat[$];
  bit          wv_pat[$];
  int nchk = 0, nbad = 0, nwe = 0, npop = 0;
  int wv_pct = 100, rr_pct = 100, wlim = 1 << 30;
  bit in_clr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: observe handshakes just before the edge, then drive next inputs at negedge.
  task automatic tick();
    bit  acc_c, acc_w;
    wr_t e;
    rd_t r;
    #1;
    if (!rst_n) chk("we_in_reset", mem_we, 0);
    else begin
      if (mem_we && !in_clr) begin
        nwe++;
        if (wq.size() == 0) chk("we_extra", mem_addr, 12'hfff + 1);
        else begin
          e = wq.pop_front();
          chk("we_addr", mem_addr, e.a);
          chk("we_data", mem_wdata, e.d);
        end
      end
      if (rsp_valid && rsp_ready) begin
        npop++;
        if (rq.size() == 0) chk("rsp_extra", rsp_data, 32'h10000);
        else begin
          r = rq.pop_front();
          chk("rsp_data", rsp_data, r.d);
          chk("rsp_last", rsp_last, r.l);
        end
      end
    end
    acc_c = rst_n && cmd_valid && cmd_ready;
    acc_w = rst_n && wr_valid && wr_ready;
    @(negedge clk);
    if (acc_c) begin
      cmd_valid = 1'b0;
      cmd_we    = 1'($urandom);
      cmd_addr  = 12'($urandom);
      cmd_len   = 12'($urandom);
    end
    if (acc_w) void'(wdq.pop_front());
    if (wv_pat.size() != 0) wr_valid = wv_pat.pop_front() && (wdq.size() != 0);
    else                    wr_valid = ($urandom_range(99) < wv_pct) && (wdq.size() != 0);
    wr_data   = (wdq.size() != 0) ? wdq[0] : 16'($urandom);
    rsp_ready = ($urandom_range(99) < rr_pct);
  endtask

  // Queue a command in the model, then offer it until accepted.
  task automatic issue(input bit we, input int addr, input int len);
    logic [11:0] a;
    logic [15:0] d;
    int n;
    for (int i = 0; i <= len; i++) begin
      a = 12'((addr + i) % 4096);
      if (we) begin
        d = (dpat.size() != 0) ? dpat.pop_front() : 16'($urandom);
        wdq.push_back(d);
        if (i < wlim) begin
          wq.push_back('{a: a, d: d});
          exp_mem[a] = d;
        end
      end else rq.push_back('{d: exp_mem[a], l: (i == len)});
    end
    cmd_we = we; cmd_addr = 12'(addr); cmd_len = 12'(len); cmd_valid = 1'b1;
    n = 0;
    while (cmd_valid && n < 20000) begin tick(); n++; end
    chk("cmd_accept_timeout", cmd_valid, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((wdq.size() != 0 || rq.size() != 0 || busy) && n < 20000) begin tick(); n++; end
    chk("drain_left", 32'(wdq.size() + rq.size()), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wdq.delete(); rq.delete(); wq.delete();
    wr_valid = 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
    begin
      int n = 0;
      in_clr = 1'b1;
      chk("clr_busy", busy, 1);
      while (!cmd_ready && n < 5000) begin tick(); n++; end
      chk("clr_cycles", n, 4096);
      for (int i = 0; i < 4096; i++) exp_mem[i] = 16'h0;
      in_clr = 1'b0;
    end
`endif
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int w0, p0, n, nmis;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 16'($urandom);
      exp_mem[i] = mem[i];
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Single write then read-back.
    wv_pct = 100; rr_pct = 100;
    dpat = '{16'hBEEF};
    w0 = nwe;
    issue(1, 'h010, 0);
    tick(); tick();
    chk("t1_we_count", nwe - w0, 1);
    chk("t1_mem", mem[12'h010], 16'hBEEF);
    issue(0, 'h010, 0);
    tick();
    chk("t1_rd_latency", rsp_valid, 1);
    drain();

    // Burst write with a stall pattern.
    wv_pct = 0;
    dpat = '{16'h1, 16'h2, 16'h3, 16'h4};
    w0 = nwe;
    issue(1, 'h100, 3);
    wv_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    n = 0;
    while (wdq.size() != 0 && n < 40) begin tick(); n++; end
    chk("t2_busy_after_last", busy, 0);
    chk("t2_we_count", nwe - w0, 4);

    // Burst read under backpressure, then full-rate drain.
    rr_pct = 0; rsp_ready = 1'b0;
    issue(0, 'h100, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_data", rsp_data, 16'h1);
    end
    rr_pct = 100; rsp_ready = 1'b1;
    p0 = npop;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_pops", npop - p0, 4);
    drain();

    // Address wrap.
    wv_pct = 100;
    dpat = '{16'hA, 16'hB, 16'hC, 16'hD};
    issue(1, 'hFFE, 3);
    drain();
    chk("t4_ffe", mem[12'hFFE], 16'hA);
    chk("t4_fff", mem[12'hFFF], 16'hB);
    chk("t4_000", mem[12'h000], 16'hC);
    chk("t4_001", mem[12'h001], 16'hD);

    // Reset in the middle of a write burst: only three beats land.
    wlim = 3;
    issue(1, 'h200, 7);
    wlim = 1 << 30;
    n = 0;
    while (wdq.size() > 5 && n < 40) begin tick(); n++; end
    chk("t5_beats_before_rst", wdq.size(), 5);
    do_reset();
    tick();
    chk("t5_cmd_ready_next", cmd_ready, 1);

    // Reset drops a pending read response.
    rr_pct = 0; rsp_ready = 1'b0;
    issue(0, 'h050, 0);
    tick();
    chk("t6_pending", rsp_valid, 1);
    do_reset();
    rr_pct = 100;

    // Full-memory sweep read.
    issue(0, 'h123, 4095);
    drain();

`ifdef MEM_CLEAR_ON_RESET_EN
    dpat = '{16'h5555};
    issue(1, 'hABC, 0);
    drain();
    chk("clr_preload", mem[12'hABC], 16'h5555);
    do_reset();
    issue(0, 'hABC, 0);
    drain();
`endif

    // Random mix, sometimes overlapping commands with pending traffic.
    for (int k = 0; k < 40; k++) begin
      wv_pct = $urandom_range(100, 30);
      rr_pct = $urandom_range(100, 30);
      issue(1'($urandom), int'($urandom_range(4095)),
            ($urandom_range(7) == 0) ? int'($urandom_range(63)) : int'($urandom_range(7)));
      if ($urandom_range(2) == 0) drain();
    end
    rr_pct = 100; wv_pct = 100;
    drain();

    nmis = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) nmis++;
    chk("mem_image", nmis, 0);
    chk("we_pending", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator side of the main-memory port.
- Accepts single or burst read/write commands over a valid/ready interface.
- Drives the memory's WE / address / write-data pins.
- Returns read data on a backpressured response stream.
- Sits between the control sequencer / DMA and the 4096x16 memory, which has a combinational read and writes on the clock edge when WE is high.

Parameters:
- AW, 12, address width (memory depth 2^AW words).
- DW, 16, data word width.
- LEN_W, 12, width of burst length field; beats = cmd_len+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_we  in  1  1=write burst, 0=read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DW  write beat data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes read data.
- rsp_data  out  DW  read data.
- rsp_last  out  1  final beat of current read burst.
- busy  out  1  state != IDLE.
- mem_we  out  1  to memory WE.
- mem_addr  out  AW  to memory address.
- mem_wdata  out  DW  to memory write data.
- mem_rdata  in  DW  from memory read data (combinational from mem_addr).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge: state=IDLE, addr=0, count=0, rsp_valid=0, rsp_data=0, rsp_last=0.
- mem_we is forced 0 whenever rst_n=0, including combinationally in the reset cycle.
- States: IDLE, WR, RD (plus CLR with the optional feature).
- IDLE:
  - cmd_ready=1, wr_ready=0, mem_we=0.
  - On cmd_valid&cmd_ready: addr<=cmd_addr, count<=cmd_len.
  - Next state WR if cmd_we=1, else RD.
- WR:
  - wr_ready=1. mem_addr=addr, mem_wdata=wr_data, mem_we=wr_valid (combinational).
  - Memory commits on the same edge as the wr handshake. Zero-cycle write latency from beat acceptance.
  - Per accepted beat: addr<=addr+1, wrapping 2^AW-1 -> 0.
  - If count==0, go to IDLE; else count<=count-1.
  - wr_valid=0 stalls indefinitely with no write.
- RD:
  - mem_addr=addr, mem_we=0.
  - Capture condition: !rsp_valid || rsp_ready.
  - When capture is true: rsp_data<=mem_rdata, rsp_valid<=1, rsp_last<=(count==0), addr advances with wrap.
  - On the last capture go to IDLE; otherwise count decrements.
  - Latency: first rsp_valid one cycle after entering RD. Sustained throughput is 1 beat/cycle when rsp_ready=1.
- Response register:
  - In any state, if rsp_valid && rsp_ready and no new capture occurs, rsp_valid<=0 and rsp_last<=0.
  - rsp_data holds while rsp_valid=1 && rsp_ready=0.
- Overlap:
  - A new command may be accepted in IDLE while the last read beat is still pending in rsp.
  - A following read cannot capture until the pending beat is consumed.
  - A following write proceeds; the pending read data is already captured, so ordering is preserved.
- cmd_len=2^LEN_W-1 with LEN_W=AW gives a full-memory sweep ending at start address-1 (mod 2^AW).
- Command fields are sampled only at acceptance; later changes are ignored.
- mem_addr in IDLE equals the addr register (no combinational path from cmd_addr).
- Reset mid-burst aborts it. Beats already written stay written. The pending response is dropped.

Optional Feature:
- Macro: MEM_CLEAR_ON_RESET_EN.
- Defined:
  - After reset the FSM enters CLR: busy=1, cmd_ready=0, mem_we=1, mem_wdata=0, mem_addr=addr.
  - addr increments from 0 to 2^AW-1 (4096 cycles), then the FSM enters IDLE with addr=0.
  - Reset during CLR restarts the sweep from 0.
- Undefined: reset goes directly to IDLE, and the memory keeps its contents.

Test Plan:
- Single write: cmd(we=1, addr=0x010, len=0), wr_data=0xBEEF -> mem_we high for exactly 1 cycle at addr 0x010; a subsequent read of 0x010 returns 0xBEEF with rsp_last=1.
- Burst write with stalls: addr=0x100, len=3, wr_valid toggled 1,0,1,1,0,1, data 0x1..0x4 -> exactly 4 writes at 0x100..0x103; busy drops the cycle after the 4th beat.
- Burst read backpressure: read addr=0x100, len=3 with rsp_ready=0 for 5 cycles, then 1 -> rsp_data holds 0x1 while stalled; then emits 0x1..0x4 on consecutive cycles, rsp_last only on 0x4.
- Wrap: write addr=0xFFE, len=3, data 0xA..0xD -> locations 0xFFE, 0xFFF, 0x000, 0x001 hold 0xA, 0xB, 0xC, 0xD.
- Reset mid-burst: write len=7 at 0x200, assert rst_n=0 after 3 beats -> only 0x200..0x202 written; rsp_valid=0, cmd_ready=1 (feature off) the cycle after release.
- MEM_CLEAR_ON_RESET_EN: preload 0x5555 at 0xABC, pulse reset -> cmd_ready=0 for 4096 cycles; a read of 0xABC then returns 0x0000.
